// File: rtl/iterative_divider.sv
// Radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU with tag pass-through,
// RISC-V divide-by-zero / signed-overflow fast paths and an abort (flush) input.
module iterative_divider #(
    parameter int WIDTH     = 32,
    parameter int TAG_W     = 5,
    parameter int EARLY_OUT = 1
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_valid,
    output logic               o_ready,
    input  logic [1:0]         i_op,
    input  logic [WIDTH-1:0]   i_A,
    input  logic [WIDTH-1:0]   i_B,
    input  logic [TAG_W-1:0]   i_tag,
    input  logic               i_flush,
    output logic               o_valid,
    input  logic               i_ready,
    output logic [WIDTH-1:0]   o_result,
    output logic [TAG_W-1:0]   o_tag,
    output logic               o_busy,
    output logic [1:0]         o_state
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [WIDTH-1:0] MIN_INT = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    // Handshakes: a request is taken on an edge where i_valid & o_ready; a result
    // is retired on an edge where o_valid & i_ready. i_flush overrides both.
    state_t             r_state;
    logic [WIDTH:0]     r_rem;
    logic [WIDTH-1:0]   r_q;
    logic [WIDTH-1:0]   r_b;
    logic [CW-1:0]      r_count;
    logic [TAG_W-1:0]   r_tag;
    logic               r_q_neg;
    logic               r_r_neg;
    logic               r_rem_op;
    logic               r_spec;
    logic [WIDTH-1:0]   r_spec_res;

    logic               w_signed;
    logic               w_a_neg;
    logic               w_b_neg;
    logic [WIDTH-1:0]   w_a_mag;
    logic [WIDTH-1:0]   w_b_mag;
    logic               w_div_zero;
    logic               w_ovf;
    logic               w_is_spec;
    logic [WIDTH-1:0]   w_spec_res;
    logic [WIDTH+1:0]   w_shift;
    logic [WIDTH+1:0]   w_diff;
    logic               w_qbit;
    logic [WIDTH-1:0]   w_rem_lo;
    logic [WIDTH-1:0]   w_q_fix;
    logic [WIDTH-1:0]   w_r_fix;
    logic [WIDTH-1:0]   w_fix_res;

    assign w_signed   = ~i_op[0];
    assign w_a_neg    = w_signed & i_A[WIDTH-1];
    assign w_b_neg    = w_signed & i_B[WIDTH-1];
    // Negating MIN_INT yields MIN_INT, which is the correct unsigned magnitude.
    assign w_a_mag    = w_a_neg ? (~i_A + 1'b1) : i_A;
    assign w_b_mag    = w_b_neg ? (~i_B + 1'b1) : i_B;
    assign w_div_zero = (i_B == '0);
    assign w_ovf      = w_signed & (i_A == MIN_INT) & (i_B == '1);
    assign w_is_spec  = w_div_zero | w_ovf;

    always_comb begin
        w_spec_res = '0;
        if (w_div_zero) begin
            w_spec_res = i_op[1] ? i_A : '1;
        end else if (w_ovf) begin
            w_spec_res = i_op[1] ? '0 : MIN_INT;
        end
    end

    // Partial remainder stays below the divisor, so bit WIDTH+1 of the
    // difference is a reliable borrow.
    assign w_shift   = {r_rem, r_q[WIDTH-1]};
    assign w_diff    = w_shift - {2'b00, r_b};
    assign w_qbit    = ~w_diff[WIDTH+1];

    assign w_rem_lo  = r_rem[WIDTH-1:0];
    assign w_q_fix   = r_q_neg ? (~r_q + 1'b1) : r_q;
    assign w_r_fix   = r_r_neg ? (~w_rem_lo + 1'b1) : w_rem_lo;
    assign w_fix_res = r_spec ? r_spec_res : (r_rem_op ? w_r_fix : w_q_fix);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state    <= S_IDLE;
            r_rem      <= '0;
            r_q        <= '0;
            r_b        <= '0;
            r_count    <= '0;
            r_tag      <= '0;
            r_q_neg    <= 1'b0;
            r_r_neg    <= 1'b0;
            r_rem_op   <= 1'b0;
            r_spec     <= 1'b0;
            r_spec_res <= '0;
            o_valid    <= 1'b0;
            o_result   <= '0;
            o_tag      <= '0;
        end else if (i_flush) begin
            r_state <= S_IDLE;
            o_valid <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_valid) begin
                        r_tag      <= i_tag;
                        r_rem      <= '0;
                        r_q        <= w_a_mag;
                        r_b        <= w_b_mag;
                        r_count    <= CW'(WIDTH);
                        r_q_neg    <= w_signed & (i_A[WIDTH-1] ^ i_B[WIDTH-1]);
                        r_r_neg    <= w_a_neg;
                        r_rem_op   <= i_op[1];
                        r_spec     <= w_is_spec;
                        r_spec_res <= w_spec_res;
                        if ((EARLY_OUT != 0) && w_is_spec) begin
                            o_result <= w_spec_res;
                            o_tag    <= i_tag;
                            o_valid  <= 1'b1;
                            r_state  <= S_DONE;
                        end else begin
                            r_state  <= S_CALC;
                        end
                    end
                end
                S_CALC: begin
                    r_rem   <= w_qbit ? w_diff[WIDTH:0] : w_shift[WIDTH:0];
                    r_q     <= {r_q[WIDTH-2:0], w_qbit};
                    r_count <= r_count - 1'b1;
                    if (r_count == CW'(1)) begin
                        r_state <= S_FIX;
                    end
                end
                S_FIX: begin
                    o_result <= w_fix_res;
                    o_tag    <= r_tag;
                    o_valid  <= 1'b1;
                    r_state  <= S_DONE;
                end
                S_DONE: begin
                    if (i_ready) begin
                        o_valid <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_ready = (r_state == S_IDLE);
    assign o_busy  = (r_state != S_IDLE);
    assign o_state = r_state;

endmodule
